// File: rtl/mm_stream_feeder_if.sv
// Write-side and stream-side handshake bundle for the matrix-multiply input feeder.
// master = firmware/test side, slave = the feeder itself.
interface mm_stream_feeder_if #(
  parameter int pDATA_WIDTH = 32
);
  logic                   in_valid;
  logic [pDATA_WIDTH-1:0] in_data;
  logic                   in_ready;
  logic                   sm_tvalid;
  logic [pDATA_WIDTH-1:0] sm_tdata;
  logic                   sm_tlast;
  logic                   sm_tready;

  modport master (
    output in_valid, in_data, sm_tready,
    input  in_ready, sm_tvalid, sm_tdata, sm_tlast
  );

  modport slave (
    input  in_valid, in_data, sm_tready,
    output in_ready, sm_tvalid, sm_tdata, sm_tlast
  );
endinterface

// File: rtl/mm_stream_feeder.sv
// First-word-fall-through FIFO between the firmware write path and the accelerator
// input stream, with frame-position tracking that marks the last beat of each frame.
module mm_stream_feeder #(
  parameter int pDATA_WIDTH = 32,
  parameter int pDEPTH      = 8,
  parameter int pFRAME_LEN  = 32
) (
  input  logic                      axis_clk,
  input  logic                      axis_rst_n,
  input  logic                      flush,
  mm_stream_feeder_if.slave         bus,
  output logic [$clog2(pDEPTH):0]   count,
  output logic                      frame_done
);
   localparam int AW = $clog2(pDEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(pFRAME_LEN);
   localparam logic [CW-1:0] FULL_CNT  = CW'(pDEPTH);
   localparam logic [BW-1:0] LAST_BEAT = BW'(pFRAME_LEN - 1);

   logic [pDATA_WIDTH-1:0] mem [pDEPTH];
   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          rd_ptr;
   logic [CW-1:0]          count_q;
   logic [BW-1:0]          beat_cnt;
   logic                   frame_done_q;
   logic                   push;
   logic                   pop;
   logic                   last_beat;

   // Both ports use valid/ready: a word transfers on a rising edge where valid and
   // ready are both high; flags come only from registered state, never from the
   // opposite side's inputs, and flush cancels any transfer in its cycle.
   assign bus.in_ready  = (count_q != FULL_CNT);
   assign bus.sm_tvalid = (count_q != '0);
   assign bus.sm_tdata  = mem[rd_ptr];
   assign last_beat     = (beat_cnt == LAST_BEAT);
   assign bus.sm_tlast  = bus.sm_tvalid & last_beat;

   assign push = bus.in_valid & bus.in_ready & ~flush;
   assign pop  = bus.sm_tvalid & bus.sm_tready & ~flush;

   assign count      = count_q;
   assign frame_done = frame_done_q;

   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count_q      <= '0;
         beat_cnt     <= '0;
         frame_done_q <= 1'b0;
      end else if (flush) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count_q      <= '0;
         beat_cnt     <= '0;
         frame_done_q <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         if (pop) beat_cnt <= last_beat ? '0 : beat_cnt + BW'(1);
         frame_done_q <= pop & last_beat;
      end
   end

   // Storage is left intact by flush; only the pointers forget it.
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         for (int i = 0; i < pDEPTH; i++) mem[i] <= '0;
      end else if (push) begin
         mem[wr_ptr] <= bus.in_data;
      end
   end
endmodule
